sponge_ctrl: RTL and testbench
==============================

SPONGE_CTRL -- requirements
Module: sponge_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, input word width in bits; legal values are 16, 32 and 64.
REQ-002 SHALL have ports ACLK, input, 1, the single clock; all logic is rising-edge.
REQ-003 SHALL have ports ARESETn, input, 1, reset; it is synchronous and active-low.
REQ-004 SHALL have s_tvalid, input, 1, message word valid.
REQ-005 SHALL have s_tready, output, 1, message word accepted when high together with s_tvalid.
REQ-006 SHALL have s_tdata, input, DATA_WIDTH, message word, little-endian within the lane.
REQ-007 SHALL have s_tlast, input, 1, last word of the message.
REQ-008 SHALL have s_tid, input, 2, mode: 0=SHA3-224, 1=SHA3-256, 2=SHA3-384, 3=SHA3-512.
REQ-009 SHALL have perm_start, output, 1, one-cycle start pulse to the Keccak-f[1600] core.
REQ-010 SHALL have perm_state_o, output, [4:0][4:0][63:0], current state; lane [y][x] = bits 64*(5y+x) upward.
REQ-011 SHALL have perm_done, input, 1, one-cycle pulse; perm_state_i is valid in the same cycle.
REQ-012 SHALL have perm_state_i, input, [4:0][4:0][63:0], permuted state.
REQ-013 SHALL have digest_valid, output, 1, digest available.
REQ-014 SHALL have digest_ready, input, 1, digest consumed when high together with digest_valid.
REQ-015 SHALL have digest, output, 512, state bits [d-1:0] zero-extended, where d = 224/256/384/512.
REQ-016 SHALL have busy, output, 1, high in any state other than ABSORB with first=1.

Function
REQ-017 SHALL hold a 1600-bit state register, a word counter wcnt, a latched mode, and flags first, pad_pending and final.
REQ-018 SHALL use rate r = 1600-2d and rate words R = r/DATA_WIDTH (64-bit: 18/17/13/9).
REQ-019 SHALL implement the FSM states ABSORB, PAD, PERM and OUTPUT; s_tready is high only in ABSORB.
REQ-020 SHALL, on each ABSORB beat, XOR s_tdata into state word wcnt; when first=1 it latches s_tid as mode and clears first; s_tid on all later beats is ignored.
REQ-021 SHALL handle a non-last beat: if wcnt==R-1, set wcnt=0 and go to PERM; otherwise wcnt+1.
REQ-022 SHALL handle a last beat: if wcnt<R-1, set wcnt+1 and go to PAD; if wcnt==R-1, set wcnt=0, set pad_pending=1 and go to PERM.
REQ-023 SHALL, in PAD (one cycle), XOR 0x06 into bits [7:0] of word wcnt, XOR 1 into state bit r-1, set final=1 and go to PERM; when both land in the same word, both XORs apply.
REQ-024 SHALL assert perm_start only in the first PERM cycle, then wait for perm_done; perm_done in the perm_start cycle is ignored.
REQ-025 SHALL, on perm_done, load the state from perm_state_i and then go to OUTPUT if final; to PAD if pad_pending (clearing it); otherwise to ABSORB.
REQ-026 SHALL hold digest_valid and digest stable in OUTPUT until digest_ready; on handshake it zeroes the state, wcnt, final and pad_pending, sets first=1 and goes to ABSORB.
REQ-027 SHALL give a latency of PAD at t+1 and perm_start at t+2 for a last beat at cycle t with wcnt<R-1; for a boundary beat, perm_start is at t+1.
REQ-028 SHALL NOT support zero-length messages; every message carries at least one word.
REQ-029 SHALL drive perm_state_o continuously from the state register.

Reset
REQ-030 SHALL, with ARESETn low at a clock edge, set FSM=ABSORB, state=0, wcnt=0, mode=0, first=1, pad_pending=0, final=0, perm_start=0, digest_valid=0 and busy=0, regardless of the current state, including mid-PERM and mid-OUTPUT.
REQ-031 SHALL ignore a perm_done that arrives after reset is released but belongs to a permutation started before reset.

Verification
REQ-032 SHALL cover reset: ARESETn low for 2 cycles during PERM -> s_tready=1, perm_start=0, digest_valid=0, perm_state_o all zero on the next cycle.
REQ-033 SHALL cover single-word SHA3-256 (DATA_WIDTH=64): s_tid=1, data 0x0123456789ABCDEF with tlast -> at perm_start, lane0=0x0123456789ABCDEF, lane1=0x06, lane16=0x8000000000000000.
REQ-034 SHALL cover the SHA3-512 boundary: 9 words with tlast on the 9th -> two perm_start pulses; the second block has lane0=0x06 and lane8=0x8000000000000000.
REQ-035 SHALL cover a multi-block SHA3-224 message of 20 words -> perm_start after word 18, s_tready low until perm_done, then PAD on word index 2 after word 20.
REQ-036 SHALL cover backpressure: digest_ready held low for 10 cycles -> digest_valid=1, digest and s_tready=0 remain stable; SHA3-384 digest bits [511:384] = 0.
REQ-037 SHALL cover mode latching: s_tid changed from 1 to 3 on the second beat -> R stays 17 and digest bits [511:256] = 0.

Source files
------------

// File: rtl/sponge_ctrl.sv
// Purpose : SHA3 sponge controller; absorbs message words, pads, sequences an external Keccak-f[1600] core.
// Latency : last beat at t -> PAD at t+1, perm_start at t+2 (rate-boundary last beat: perm_start at t+1).
// Backpr. : s_tready low outside ABSORB; digest held stable in OUTPUT until digest_ready.
//
// Ports:
//   ACLK, ARESETn             clock, synchronous active-low reset
//   s_tvalid/s_tready/s_tdata message word stream; s_tlast marks the final word,
//   s_tlast/s_tid             s_tid selects mode on the first word (0..3 = SHA3-224/256/384/512)
//   perm_start/perm_state_o   start pulse and current state towards the permutation core
//   perm_done/perm_state_i    completion pulse and permuted state from the core
//   digest_valid/digest_ready digest handshake; digest = low d bits of the state, zero-extended
//   busy                      high unless idle in ABSORB waiting for a new message
module sponge_ctrl #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                   ACLK,
  input  logic                   ARESETn,
  input  logic                   s_tvalid,
  output logic                   s_tready,
  input  logic [DATA_WIDTH-1:0]  s_tdata,
  input  logic                   s_tlast,
  input  logic [1:0]             s_tid,
  output logic                   perm_start,
  output logic [4:0][4:0][63:0]  perm_state_o,
  input  logic                   perm_done,
  input  logic [4:0][4:0][63:0]  perm_state_i,
  output logic                   digest_valid,
  input  logic                   digest_ready,
  output logic [511:0]           digest,
  output logic                   busy
);

  localparam int WCW = 7;   // up to 72 rate words at 16-bit lanes
  localparam int IW  = 11;  // bit index into the 1600-bit state

  typedef enum logic [1:0] {
    ABSORB = 2'd0,
    PAD    = 2'd1,
    PERM   = 2'd2,
    OUTPUT = 2'd3
  } fsm_t;

  fsm_t             fsm;
  logic [1599:0]    st;
  logic [WCW-1:0]   wcnt;
  logic [1:0]       mode;
  logic             first;
  logic             pad_pending;
  logic             final_flag;

  function automatic int rate_bits(input logic [1:0] m);
    case (m)
      2'd0:    return 1152;
      2'd1:    return 1088;
      2'd2:    return 832;
      default: return 576;
    endcase
  endfunction

  // On the first beat the mode is not latched yet, so the rate comes from s_tid.
  logic [1:0]     cur_mode;
  logic [WCW-1:0] last_idx;
  logic [IW-1:0]  word_base;
  logic [IW-1:0]  rate_top;
  logic [1599:0]  absorb_mask;
  logic [1599:0]  pad_mask;

  assign cur_mode  = first ? s_tid : mode;
  assign last_idx  = WCW'(rate_bits(cur_mode) / DATA_WIDTH - 1);
  assign word_base = IW'(wcnt) * IW'(DATA_WIDTH);
  assign rate_top  = IW'(rate_bits(mode) - 1);

  always_comb begin
    absorb_mask = '0;
    absorb_mask[word_base +: DATA_WIDTH] = s_tdata;
  end

  // Domain byte 0x06 at the next free word plus the final 1 at bit r-1;
  // built as one mask so both flips apply even if they share a word.
  always_comb begin
    pad_mask = '0;
    pad_mask[word_base +: 8] = 8'h06;
    pad_mask[rate_top] = ~pad_mask[rate_top];
  end

  always_comb begin
    digest = '0;
    case (mode)
      2'd0:    digest[223:0] = st[223:0];
      2'd1:    digest[255:0] = st[255:0];
      2'd2:    digest[383:0] = st[383:0];
      default: digest        = st[511:0];
    endcase
  end

  assign s_tready     = (fsm == ABSORB);
  assign busy         = !((fsm == ABSORB) && first);
  assign perm_state_o = st;

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      fsm          <= ABSORB;
      st           <= '0;
      wcnt         <= '0;
      mode         <= 2'd0;
      first        <= 1'b1;
      pad_pending  <= 1'b0;
      final_flag   <= 1'b0;
      perm_start   <= 1'b0;
      digest_valid <= 1'b0;
    end else begin
      perm_start <= 1'b0;
      case (fsm)
        ABSORB: begin
          if (s_tvalid) begin
            st <= st ^ absorb_mask;
            if (first) begin
              mode  <= s_tid;
              first <= 1'b0;
            end
            if (wcnt == last_idx) begin
              // Block full: permute now; a last word here needs an extra padding block.
              wcnt       <= '0;
              fsm        <= PERM;
              perm_start <= 1'b1;
              if (s_tlast) pad_pending <= 1'b1;
            end else begin
              wcnt <= wcnt + WCW'(1);
              if (s_tlast) fsm <= PAD;
            end
          end
        end
        PAD: begin
          st         <= st ^ pad_mask;
          final_flag <= 1'b1;
          fsm        <= PERM;
          perm_start <= 1'b1;
        end
        PERM: begin
          // A done pulse coinciding with our own start pulse cannot belong to this run.
          if (perm_done && !perm_start) begin
            st <= perm_state_i;
            if (final_flag) begin
              fsm          <= OUTPUT;
              digest_valid <= 1'b1;
            end else if (pad_pending) begin
              pad_pending <= 1'b0;
              fsm         <= PAD;
            end else begin
              fsm <= ABSORB;
            end
          end
        end
        OUTPUT: begin
          if (digest_ready) begin
            st           <= '0;
            wcnt         <= '0;
            final_flag   <= 1'b0;
            pad_pending  <= 1'b0;
            first        <= 1'b1;
            digest_valid <= 1'b0;
            fsm          <= ABSORB;
          end
        end
        default: fsm <= ABSORB;
      endcase
    end
  end

endmodule

// File: tb/tb_sponge_ctrl.sv
module tb_sponge_ctrl;

  logic                  ACLK = 1'b0;
  logic                  ARESETn;
  logic                  s_tvalid;
  logic                  s_tready;
  logic [63:0]           s_tdata;
  logic                  s_tlast;
  logic [1:0]            s_tid;
  logic                  perm_start;
  logic [4:0][4:0][63:0] perm_state_o;
  logic                  perm_done;
  logic [4:0][4:0][63:0] perm_state_i;
  logic                  digest_valid;
  logic                  digest_ready;
  logic [511:0]          digest;
  logic                  busy;

  always #5 ACLK = ~ACLK;

  sponge_ctrl #(.DATA_WIDTH(64)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
    .s_tlast(s_tlast), .s_tid(s_tid),
    .perm_start(perm_start), .perm_state_o(perm_state_o),
    .perm_done(perm_done), .perm_state_i(perm_state_i),
    .digest_valid(digest_valid), .digest_ready(digest_ready),
    .digest(digest), .busy(busy)
  );

  int checks = 0;
  int passed = 0;

  logic [1599:0] exp_q[$];
  logic [1599:0] cap_q[$];
  time           ps_t[$];
  time           acc_t[$];
  int            ps_count = 0;
  int            core_cnt = 0;
  int            core_lat = 0;
  bit            expect_stale = 1'b0;
  logic [1599:0] core_buf;

  // Stand-in permutation: any fixed bijection works for a controller check.
  function automatic logic [1599:0] fperm(input logic [1599:0] s);
    return {s[1598:0], s[1599]} ^ {25{64'h9E3779B97F4A7C15}};
  endfunction

  function automatic int rate_words(input int m);
    return (1600 - 2 * dbits(m)) / 64;
  endfunction

  function automatic int dbits(input int m);
    case (m)
      0:       return 224;
      1:       return 256;
      2:       return 384;
      default: return 512;
    endcase
  endfunction

  function automatic logic [511:0] dmask(input int d);
    logic [511:0] m;
    for (int i = 0; i < 512; i++) m[i] = (i < d);
    return m;
  endfunction

  task automatic chk(input string tag, input logic [511:0] o, input logic [511:0] e);
    checks++;
    assert (o === e) passed++;
    else $error("FAIL %s observed %0h expected %0h", tag, o, e);
  endtask

  task automatic chk_state(input string tag, input logic [1599:0] o, input logic [1599:0] e);
    int k;
    checks++;
    assert (o === e) passed++;
    else begin
      k = 0;
      for (int i = 24; i >= 0; i--) if (o[64*i +: 64] !== e[64*i +: 64]) k = i;
      $error("FAIL %s lane %0d observed %h expected %h", tag, k, o[64*k +: 64], e[64*k +: 64]);
    end
  endtask

  // Permutation core model: captures the state on perm_start, answers after a delay.
  initial begin
    perm_done    = 1'b0;
    perm_state_i = '0;
    forever begin
      @(negedge ACLK);
      perm_done = 1'b0;
      if (perm_start === 1'b1) begin
        ps_count++;
        ps_t.push_back($time);
        cap_q.push_back(perm_state_o);
        chk("perm_start_expected", 512'(exp_q.size() != 0), 512'd1);
        if (exp_q.size() != 0) chk_state("perm_block", perm_state_o, exp_q.pop_front());
        chk("tready_in_perm", 512'(s_tready), 512'd0);
        core_buf = fperm(perm_state_o);
        core_cnt = (core_lat != 0) ? core_lat : int'($urandom_range(1, 4));
        if ($urandom_range(0, 1) == 1) begin
          perm_done    = 1'b1;
          perm_state_i = {25{64'hDEADBEEFCAFEF00D}};
        end
      end else if (core_cnt > 0) begin
        core_cnt--;
        if (core_cnt == 0) begin
          if (!expect_stale) chk("tready_at_done", 512'(s_tready), 512'd0);
          perm_done    = 1'b1;
          perm_state_i = expect_stale ? {25{64'h5A5A5A5AA5A5A5A5}} : core_buf;
        end
      end
    end
  end

  task automatic drive_word(input logic [63:0] d, input logic [1:0] tid, input bit last);
    int guard;
    repeat ($urandom_range(0, 2)) @(negedge ACLK);
    @(negedge ACLK);
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tid    = tid;
    s_tlast  = last;
    guard    = 0;
    while (s_tready !== 1'b1) begin
      @(negedge ACLK);
      guard++;
      if (guard > 300) begin
        checks++;
        $error("FAIL s_tready_wait observed timeout expected handshake");
        break;
      end
    end
    acc_t.push_back($time);
    @(posedge ACLK);
    #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic run_msg(input int mode, input int n, input bit tid_chg, input int hold,
                         input logic [63:0] first_word);
    int            R, nb, d, guard;
    logic [63:0]   msg[];
    logic [63:0]   pw[];
    logic [1599:0] S;
    logic [511:0]  dig;
    logic [1:0]    tid;
    R   = rate_words(mode);
    nb  = n / R + 1;
    d   = dbits(mode);
    msg = new[n];
    for (int i = 0; i < n; i++) msg[i] = (i == 0) ? first_word : {$urandom, $urandom};
    pw = new[nb * R];
    for (int i = 0; i < nb * R; i++) pw[i] = (i < n) ? msg[i] : 64'd0;
    pw[n]          = pw[n] ^ 64'h06;
    pw[nb * R - 1] = pw[nb * R - 1] ^ 64'h8000000000000000;
    S = '0;
    for (int b = 0; b < nb; b++) begin
      for (int i = 0; i < R; i++) S[64*i +: 64] = S[64*i +: 64] ^ pw[b * R + i];
      exp_q.push_back(S);
      S = fperm(S);
    end
    dig = S[511:0] & dmask(d);
    ps_count = 0;
    cap_q.delete();
    ps_t.delete();
    acc_t.delete();
    for (int i = 0; i < n; i++) begin
      tid = (i == 0) ? 2'(mode) : (tid_chg ? 2'd3 : 2'($urandom_range(0, 3)));
      drive_word(msg[i], tid, i == n - 1);
    end
    guard = 0;
    while (digest_valid !== 1'b1 && guard < 400) begin
      @(negedge ACLK);
      guard++;
    end
    chk("digest_valid", 512'(digest_valid), 512'd1);
    chk("busy_output", 512'(busy), 512'd1);
    chk("digest", digest, dig);
    chk("digest_upper_zero", digest & ~dmask(d), 512'd0);
    chk("perm_count", 512'(ps_count), 512'(nb));
    chk("blocks_consumed", 512'(exp_q.size()), 512'd0);
    repeat (hold) begin
      @(negedge ACLK);
      chk("hold_valid", 512'(digest_valid), 512'd1);
      chk("hold_digest", digest, dig);
      chk("hold_tready", 512'(s_tready), 512'd0);
    end
    digest_ready = 1'b1;
    @(posedge ACLK);
    #1;
    digest_ready = 1'b0;
    @(negedge ACLK);
    chk("post_tready", 512'(s_tready), 512'd1);
    chk("post_busy", 512'(busy), 512'd0);
    chk("post_valid", 512'(digest_valid), 512'd0);
    chk_state("post_state_zero", perm_state_o, 1600'd0);
    exp_q.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1599:0] blk;
    logic [1599:0] exp1;
    int            guard;

    ARESETn      = 1'b0;
    s_tvalid     = 1'b0;
    s_tdata      = '0;
    s_tlast      = 1'b0;
    s_tid        = 2'd0;
    digest_ready = 1'b0;
    repeat (3) @(posedge ACLK);
    #1;
    ARESETn = 1'b1;
    @(negedge ACLK);
    chk("rst_tready", 512'(s_tready), 512'd1);
    chk("rst_perm_start", 512'(perm_start), 512'd0);
    chk("rst_digest_valid", 512'(digest_valid), 512'd0);
    chk("rst_busy", 512'(busy), 512'd0);
    chk_state("rst_state", perm_state_o, 1600'd0);

    // Single-word SHA3-256: padding lands in the same block.
    run_msg(1, 1, 1'b0, 0, 64'h0123456789ABCDEF);
    blk = cap_q[0];
    chk("s256_lane0", 512'(blk[63:0]), 512'h0123456789ABCDEF);
    chk("s256_lane1", 512'(blk[127:64]), 512'h06);
    chk("s256_lane16", 512'(blk[16*64 +: 64]), 512'h8000000000000000);
    chk("s256_latency", 512'((ps_t[0] - acc_t[0]) / 10), 512'd2);

    // Reset while the core is still permuting; its late done must be ignored.
    core_lat     = 8;
    expect_stale = 1'b1;
    exp1 = '0;
    exp1[63:0]         = 64'hFEEDFACE01234567;
    exp1[127:64]       = 64'h06;
    exp1[16*64 +: 64]  = 64'h8000000000000000;
    exp_q.push_back(exp1);
    ps_count = 0;
    drive_word(64'hFEEDFACE01234567, 2'd1, 1'b1);
    guard = 0;
    while (ps_count == 0 && guard < 50) begin
      @(negedge ACLK);
      guard++;
    end
    chk("rstperm_started", 512'(ps_count), 512'd1);
    @(posedge ACLK);
    #1;
    ARESETn = 1'b0;
    repeat (2) @(posedge ACLK);
    #1;
    ARESETn = 1'b1;
    @(negedge ACLK);
    chk("rstperm_tready", 512'(s_tready), 512'd1);
    chk("rstperm_perm_start", 512'(perm_start), 512'd0);
    chk("rstperm_valid", 512'(digest_valid), 512'd0);
    chk_state("rstperm_state", perm_state_o, 1600'd0);
    guard = 0;
    while (core_cnt != 0 && guard < 50) begin
      @(negedge ACLK);
      guard++;
    end
    repeat (2) @(negedge ACLK);
    chk_state("stale_done_state", perm_state_o, 1600'd0);
    chk("stale_done_busy", 512'(busy), 512'd0);
    chk("stale_done_tready", 512'(s_tready), 512'd1);
    expect_stale = 1'b0;
    core_lat     = 0;
    exp_q.delete();

    // SHA3-512 rate boundary: padding needs its own block.
    run_msg(3, 9, 1'b0, 0, {$urandom, $urandom});
    blk = cap_q[1] ^ fperm(cap_q[0]);
    chk("s512_pad_lane0", 512'(blk[63:0]), 512'h06);
    chk("s512_pad_lane8", 512'(blk[8*64 +: 64]), 512'h8000000000000000);
    chk("s512_pad_mid_zero", 512'(blk[8*64-1:64]), 512'd0);
    chk("s512_boundary_latency", 512'((ps_t[0] - acc_t[8]) / 10), 512'd1);

    // SHA3-224, 20 words: one full block then a padded tail at word 2.
    run_msg(0, 20, 1'b0, 0, {$urandom, $urandom});
    blk = cap_q[1] ^ fperm(cap_q[0]);
    chk("s224_block1_latency", 512'((ps_t[0] - acc_t[17]) / 10), 512'd1);
    chk("s224_word19_after_perm", 512'(acc_t[18] > ps_t[0]), 512'd1);
    chk("s224_pad_lane2", 512'(blk[2*64 +: 64]), 512'h06);
    chk("s224_pad_lane17", 512'(blk[17*64 +: 64]), 512'h8000000000000000);
    chk("s224_tail_latency", 512'((ps_t[1] - acc_t[19]) / 10), 512'd2);

    // SHA3-384 with digest_ready held off for 10 cycles.
    run_msg(2, 5, 1'b0, 10, {$urandom, $urandom});

    // Mode latched on the first beat; later s_tid=3 must not change the rate.
    run_msg(1, 18, 1'b1, 0, {$urandom, $urandom});

    for (int k = 0; k < 8; k++)
      run_msg(int'($urandom_range(0, 3)), int'($urandom_range(1, 40)), 1'b0,
              int'($urandom_range(0, 3)), {$urandom, $urandom});

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
